// File: rtl/shifter_iter_pkg.sv
// Shared encodings and defaults for the iterative shifter.
// The optional early-exit feature is enabled with SHIFTER_ITER_EARLY_EXIT_EN.
package shifter_iter_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 4;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shifter_iter_shift_step.sv
// Combinational single-bit step of the value under one of the four shift ops.
module shifter_iter_shift_step
    import shifter_iter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        case (op)
            OP_ROL:  result = {data[WIDTH-2:0], data[WIDTH-1]};
            OP_SLL:  result = {data[WIDTH-2:0], 1'b0};
            OP_SRA:  result = {data[WIDTH-1], data[WIDTH-1:1]};
            OP_SRL:  result = {1'b0, data[WIDTH-1:1]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shifter_iter.sv
// Iterative shifter: one 1-bit step per clock until the latched count runs out.
// Define SHIFTER_ITER_EARLY_EXIT_EN to finish as soon as the value stops changing.
module shifter_iter
    import shifter_iter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // start/busy handshake: start is taken in any cycle where busy is low
    // (IDLE or DONE); while busy is high it is dropped, never queued.

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] step_val;
    logic             accept;
    logic             fixed;

    assign accept    = start && (state != ST_SHIFT);
    assign dbg_state = state;

    shifter_iter_shift_step #(.WIDTH(WIDTH)) u_step (
        .data   (Out),
        .op     (op_r),
        .result (step_val)
    );

`ifdef SHIFTER_ITER_EARLY_EXIT_EN
    // Further steps cannot change a fixed point, so stopping early is exact.
    assign fixed = (op_r != OP_ROL) &&
                   ((step_val == '0) || ((op_r == OP_SRA) && (step_val == '1)));
`else
    assign fixed = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_next = (Cnt == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if ((cnt_r == CNT_W'(1)) || fixed) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Out   <= '0;
            cnt_r <= '0;
            op_r  <= OP_ROL;
        end else if (accept) begin
            Out   <= In;
            cnt_r <= Cnt;
            op_r  <= Op;
        end else if (state == ST_SHIFT) begin
            Out   <= step_val;
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shifter_iter.sv
// Directed bench for shifter_iter: vector table plus hand-written multi-cycle cases.
module tb_shifter_iter;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_v;
    logic [3:0]  cnt_v;
    logic [1:0]  op_v;
    logic [15:0] out_v;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [3:0]  c;
        logic [1:0]  o;
        logic [15:0] exp;
        int          lat_full;
        int          lat_early;
    } vec_t;

    vec_t vecs[15];

    shifter_iter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .In        (in_v),
        .Cnt       (cnt_v),
        .Op        (op_v),
        .Out       (out_v),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op at the next negedge (cycle 0) and follow it to done.
    task automatic run_op(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                          input logic [15:0] exp, input int lat, input string name);
        int got_cyc;
        int busy_n;
        got_cyc = 0;
        busy_n  = 0;
        @(negedge clk);
        in_v = a; cnt_v = c; op_v = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_v  = 16'($urandom);
        cnt_v = 4'($urandom);
        op_v  = 2'($urandom);
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                got_cyc = k;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
        check({name, " latency"}, got_cyc, lat);
        check({name, " out"}, out_v, exp);
        check({name, " busy cycles"}, busy_n, lat - 1);
        @(negedge clk);
        check({name, " done pulse"}, {busy, done}, 2'b00);
        check({name, " out hold"}, out_v, exp);
    endtask

    initial begin
        vecs[0]  = '{16'h8001, 4'd1,  2'b00, 16'h0003, 2,  2};
        vecs[1]  = '{16'h8000, 4'd15, 2'b10, 16'hFFFF, 16, 16};
        vecs[2]  = '{16'h8000, 4'd15, 2'b11, 16'h0001, 16, 16};
        vecs[3]  = '{16'h1234, 4'd0,  2'b01, 16'h1234, 1,  1};
        vecs[4]  = '{16'h8000, 4'd15, 2'b01, 16'h0000, 16, 2};
        vecs[5]  = '{16'h00F0, 4'd4,  2'b01, 16'h0F00, 5,  5};
        vecs[6]  = '{16'h1234, 4'd4,  2'b00, 16'h2341, 5,  5};
        vecs[7]  = '{16'h1234, 4'd8,  2'b00, 16'h3412, 9,  9};
        vecs[8]  = '{16'hF0F0, 4'd3,  2'b10, 16'hFE1E, 4,  4};
        vecs[9]  = '{16'h0F0F, 4'd4,  2'b11, 16'h00F0, 5,  5};
        vecs[10] = '{16'h0003, 4'd5,  2'b11, 16'h0000, 6,  3};
        vecs[11] = '{16'h7FFF, 4'd15, 2'b10, 16'h0000, 16, 16};
        vecs[12] = '{16'hFFFF, 4'd3,  2'b10, 16'hFFFF, 4,  2};
        vecs[13] = '{16'hABCD, 4'd15, 2'b00, 16'hD5E6, 16, 16};
        vecs[14] = '{16'h5555, 4'd1,  2'b01, 16'hAAAA, 2,  2};

        rst = 1'b1; start = 1'b0; in_v = '0; cnt_v = '0; op_v = '0;
        repeat (3) @(negedge clk);
        check("reset out", out_v, 16'h0000);
        check("reset flags", {busy, done}, 2'b00);
        check("reset state", dbg_state, 2'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
`ifdef SHIFTER_ITER_EARLY_EXIT_EN
            run_op(vecs[i].a, vecs[i].c, vecs[i].o, vecs[i].exp, vecs[i].lat_early,
                   $sformatf("vec%0d", i));
`else
            run_op(vecs[i].a, vecs[i].c, vecs[i].o, vecs[i].exp, vecs[i].lat_full,
                   $sformatf("vec%0d", i));
`endif
        end

        // Start while busy is ignored; start in the DONE cycle is accepted.
        begin
            int got_cyc;
            got_cyc = 0;
            @(negedge clk);
            in_v = 16'h0001; cnt_v = 4'd4; op_v = 2'b01; start = 1'b1;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                start = (k == 2);
                in_v  = (k == 2) ? 16'hFFFF : 16'h0000;
                if (done) begin
                    got_cyc = k;
                    break;
                end
            end
            check("busy start latency", got_cyc, 5);
            check("busy start out", out_v, 16'h0010);
            in_v = 16'h0003; cnt_v = 4'd2; op_v = 2'b00; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("b2b accepted", {busy, out_v}, {1'b1, 16'h0003});
            got_cyc = 0;
            for (int k = 1; k <= 30; k++) begin
                if (done) begin
                    got_cyc = k;
                    break;
                end
                @(negedge clk);
            end
            check("b2b latency", got_cyc, 3);
            check("b2b out", out_v, 16'h000C);
            @(negedge clk);
        end

        // Reset mid-operation abandons the shift with no done pulse.
        begin
            int done_seen;
            done_seen = 0;
            @(negedge clk);
            in_v = 16'hF000; cnt_v = 4'd8; op_v = 2'b11; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("mid reset out", out_v, 16'h0000);
            check("mid reset flags", {busy, done}, 2'b00);
            for (int k = 0; k < 12; k++) begin
                if (done) done_seen++;
                @(negedge clk);
            end
            check("mid reset no done", done_seen, 0);
            run_op(16'h00F0, 4'd2, 2'b11, 16'h003C, 3, "after reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shifter_iter.md
Name: shifter_iter

Overview:
- Multi-cycle iterative shifter for the 16-bit datapath.
- Loads an operand, a shift count and a shift op, then applies exactly one 1-bit shift per clock until the count is exhausted.
- Feeds the execute-stage result mux. It is the area-saving alternative to a fully unrolled barrel shifter for shift/rotate instructions.
- Stalls the pipeline through `busy`.

Parameters:
- WIDTH, 16, datapath width in bits.
- CNT_W, 4, shift-count width (maximum shift is 2^CNT_W - 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when not busy.
- In  input  WIDTH  operand.
- Cnt  input  CNT_W  number of 1-bit shifts.
- Op  input  2  00 rotate left, 01 shift left logical, 10 shift right arithmetic, 11 shift right logical.
- Out  output  WIDTH  result register.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse when `Out` is final.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - `Out`=0, `busy`=0, `done`=0, internal count=0, latched op=00.
  - Reset mid-operation abandons the shift immediately; no `done` is produced.
- States:
  - IDLE, SHIFT, DONE.
  - IDLE: on `start`, latch `In`→`Out`, `Cnt`→remaining count, `Op`→latched op.
    - Cnt==0 → DONE.
    - Otherwise → SHIFT.
  - SHIFT: each cycle, `Out` ← one-bit step of `Out` under the latched op, and remaining count decrements.
    - When the count reaches 0 after the step → DONE.
    - `busy`=1 throughout SHIFT.
  - DONE: `done`=1 for exactly this cycle and `busy`=0. The DONE cycle accepts `start` exactly as IDLE does (back-to-back ops); otherwise → IDLE.
- Latency: `start` in cycle 0 with Cnt=N gives `done` in cycle N+1. Cnt=0 gives `done` in cycle 1 with `Out`=`In`.
- Handshakes and registers:
  - `start` while `busy`=1 is ignored; it is neither queued nor errored.
  - `In`/`Cnt`/`Op` changes after acceptance have no effect.
  - `Out` holds its value in IDLE/DONE until the next accepted `start`.
- One-bit step rules:
  - ROL: bit0 ← bit15.
  - SLL: bit0 ← 0.
  - SRA: bit15 ← bit15.
  - SRL: bit15 ← 0.
- Arithmetic is modulo rotation (ROL by 16 is not reachable; max 15).

Optional Feature:
- Macro SHIFTER_ITER_EARLY_EXIT_EN.
- Defined: in SHIFT, if the value after the current step is a fixed point of the latched op, go to DONE immediately regardless of remaining count.
  - Fixed points: SLL/SRL value 0x0000; SRA value 0x0000 or 0xFFFF.
  - ROL never exits early.
  - The result is bit-identical to full iteration; only latency shrinks.
- Undefined: always exactly Cnt shift cycles.

Decomposition:
- Shared package holds:
  - Op encoding constants OP_ROL=2'b00, OP_SLL=2'b01, OP_SRA=2'b10, OP_SRL=2'b11.
  - State encoding constants ST_IDLE, ST_SHIFT, ST_DONE.
  - WIDTH/CNT_W defaults.
- One sub-module is natural: shift_step, a combinational single-bit step (data, op → data) instantiated once inside the datapath loop.

Test Plan:
- ROL: In=0x8001, Cnt=1, Op=00, start at cycle 0 → `done` in cycle 2, `Out`=0x0003, `busy` high in cycle 1 only.
- SRA vs SRL: In=0x8000, Cnt=15, Op=10 → `Out`=0xFFFF, `done` in cycle 16. Same with Op=11 → `Out`=0x0001.
- Cnt=0: In=0x1234, Cnt=0, Op=01 → `done` in cycle 1, `Out`=0x1234, `busy` never asserted.
- Start while busy: SLL In=0x0001 Cnt=4; pulse `start` with In=0xFFFF in cycle 2 → ignored, `Out`=0x0010 at `done` (cycle 5). Then a new `start` in the DONE cycle is accepted.
- Reset mid-op: SRL In=0xF000 Cnt=8; `rst` in cycle 3 → next cycle `Out`=0, `busy`=0, `done` never pulses. A following op completes normally.
- Early exit: SLL In=0x8000 Cnt=15.
  - With SHIFTER_ITER_EARLY_EXIT_EN: `done` in cycle 2, `Out`=0x0000.
  - Without it: `done` in cycle 16, `Out`=0x0000.
